// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
//   Byte FIFO between the CPU-side UART IO decode and the UART transmit core.
//   IO writes are queued here so software can poll "full" instead of the
//   per-byte core busy flag; a small drain FSM feeds the core one byte at a
//   time over its data_in / data_in_wr / busy_tx handshake.
//
// Parameters
//   DEPTH_LOG2 : FIFO depth is 2**DEPTH_LOG2 entries
//   BUSY_WAIT  : cycles to wait for tx_busy to rise after a tx_wr pulse
//
// Ports
//   clk      in   system clock (UART core domain)
//   reset    in   synchronous, active-high reset
//   wr_data  in   byte from IO decode
//   wr_en    in   push wr_data this cycle (dropped when full)
//   full     out  FIFO holds DEPTH entries
//   empty    out  FIFO holds 0 entries and no byte is in flight
//   count    out  FIFO occupancy, excluding the byte in flight
//   tx_data  out  byte to core data_in, stable from issue until back in IDLE
//   tx_wr    out  1-cycle write strobe to core data_in_wr
//   tx_busy  in   core busy_tx
//
// Optional feature (macro UART_TX_FIFO_OVF_EN)
//   ovf_clr  in   clears the sticky overflow flag
//   ovf      out  sticky flag, set by a write while full (set wins over clear)
//
// Drain FSM
//   state     | meaning
//   ----------+------------------------------------------------------------
//   IDLE      | waiting for a queued byte and an idle core; pops into tx_data
//   ISSUE     | tx_wr high for this single cycle; loads the busy wait timer
//   WAIT_BUSY | waiting for the core to raise busy; timeout drops the byte
//   WAIT_DONE | core is sending the frame; wait for busy to fall

module uart_tx_fifo #(
  parameter int DEPTH_LOG2 = 4,
  parameter int BUSY_WAIT  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            wr_data,
  input  logic                  wr_en,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count,
  output logic [7:0]            tx_data,
  output logic                  tx_wr,
  input  logic                  tx_busy
`ifdef UART_TX_FIFO_OVF_EN
  ,
  input  logic                  ovf_clr,
  output logic                  ovf
`endif
);

  localparam int DEPTH  = 2 ** DEPTH_LOG2;
  localparam int WAIT_W = (BUSY_WAIT < 1) ? 1 : $clog2(BUSY_WAIT + 1);

  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [WAIT_W-1:0]   WAIT_LOAD = WAIT_W'(BUSY_WAIT);
  localparam logic [WAIT_W-1:0]   WAIT_ONE  = WAIT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ISSUE     = 2'd1,
    S_WAIT_BUSY = 2'd2,
    S_WAIT_DONE = 2'd3
  } state_t;

  logic [7:0]            mem_q [DEPTH];

  state_t                state_q,    state_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q,   rd_ptr_d;
  logic [DEPTH_LOG2-1:0] wr_ptr_q,   wr_ptr_d;
  logic [DEPTH_LOG2:0]   count_q,    count_d;
  logic [7:0]            tx_data_q,  tx_data_d;
  logic                  tx_wr_q,    tx_wr_d;
  logic [WAIT_W-1:0]     wait_cnt_q, wait_cnt_d;

  logic full_int;
  logic push;
  logic pop;

  assign full_int = (count_q == DEPTH_CNT);
  // A write while full is dropped, even if IDLE pops in the same cycle.
  assign push     = wr_en && !full_int;

  always_comb begin
    state_d    = state_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    tx_data_d  = tx_data_q;
    tx_wr_d    = 1'b0;
    wait_cnt_d = wait_cnt_q;
    pop        = 1'b0;

    case (state_q)
      S_IDLE: begin
        // No bypass: a byte pushed this cycle is only visible next cycle.
        if ((count_q != '0) && !tx_busy) begin
          pop       = 1'b1;
          tx_data_d = mem_q[rd_ptr_q];
          tx_wr_d   = 1'b1;
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        wait_cnt_d = WAIT_LOAD;
        state_d    = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = S_WAIT_DONE;
        end else begin
          // Terminal count: the decrement that reaches zero returns to IDLE,
          // so WAIT_BUSY lasts BUSY_WAIT cycles. The missed byte is not retried.
          wait_cnt_d = wait_cnt_q - WAIT_ONE;
          if (wait_cnt_q <= WAIT_ONE) begin
            state_d = S_IDLE;
          end
        end
      end
      S_WAIT_DONE: begin
        if (!tx_busy) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      tx_data_q  <= 8'h00;
      tx_wr_q    <= 1'b0;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      tx_data_q  <= tx_data_d;
      tx_wr_q    <= tx_wr_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Storage needs no reset: count_q alone says which entries are valid.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

`ifdef UART_TX_FIFO_OVF_EN
  logic ovf_q, ovf_d;

  always_comb begin
    ovf_d = ovf_q;
    if (ovf_clr) begin
      ovf_d = 1'b0;
    end
    if (wr_en && full_int) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`endif

  assign full    = full_int;
  assign empty   = (count_q == '0) && (state_q == S_IDLE);
  assign count   = count_q;
  assign tx_data = tx_data_q;
  assign tx_wr   = tx_wr_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Testbench for uart_tx_fifo. Stimulus pushes expected bytes into a queue;
// a negedge monitor pops and compares on every tx_wr pulse. A small core model
// drives tx_busy: normal (busy rises one cycle after tx_wr and lasts 20
// cycles), held busy, or never responding.

module tb_uart_tx_fifo;

  localparam int DEPTH_LOG2 = 4;
  localparam int BUSY_WAIT  = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] wr_data;
  logic       wr_en;
  logic       full;
  logic       empty;
  logic [4:0] count;
  logic [7:0] tx_data;
  logic       tx_wr;
  logic       tx_busy;
`ifdef UART_TX_FIFO_OVF_EN
  logic       ovf_clr;
  logic       ovf;
`endif

  uart_tx_fifo #(
    .DEPTH_LOG2(DEPTH_LOG2),
    .BUSY_WAIT (BUSY_WAIT)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .wr_data(wr_data),
    .wr_en  (wr_en),
    .full   (full),
    .empty  (empty),
    .count  (count),
    .tx_data(tx_data),
    .tx_wr  (tx_wr),
    .tx_busy(tx_busy)
`ifdef UART_TX_FIFO_OVF_EN
    ,
    .ovf_clr(ovf_clr),
    .ovf    (ovf)
`endif
  );

  always #5 clk = ~clk;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] sb[$];
  int         pulse_cyc[$];
  int         cyc = 0;

  always @(posedge clk) cyc++;

  // Core model
  bit hold_busy     = 1'b0;
  bit core_responds = 1'b1;
  int busy_left     = 0;
  bit start_pending = 1'b0;

  initial begin
    tx_busy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (start_pending) begin
        busy_left     = 20;
        start_pending = 1'b0;
      end
      if (tx_wr && core_responds) start_pending = 1'b1;
      if (hold_busy) begin
        tx_busy = 1'b1;
      end else if (busy_left > 0) begin
        tx_busy = 1'b1;
        busy_left--;
      end else begin
        tx_busy = 1'b0;
      end
    end
  end

  // Monitor / scoreboard
  logic       prev_wr = 1'b0;
  logic [7:0] exp_byte;
  always @(negedge clk) begin
    if (tx_wr === 1'b1) begin
      pulse_cyc.push_back(cyc);
      n_tests++;
      if (prev_wr) begin
        n_fail++;
        $display("FAIL tx_wr_double: tx_wr high two cycles in a row at cycle %0d (required single pulse)", cyc);
      end else if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL tx_wr_unexpected: pulse with tx_data=%02h at cycle %0d, no byte expected", tx_data, cyc);
      end else begin
        exp_byte = sb.pop_front();
        if (tx_data !== exp_byte) begin
          n_fail++;
          $display("FAIL tx_data: got %02h required %02h at cycle %0d", tx_data, exp_byte, cyc);
        end
      end
    end
    prev_wr = tx_wr;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Called at posedge+1; returns at the following posedge+1.
  task automatic push(input logic [7:0] d, input bit accepted);
    wr_data = d;
    wr_en   = 1'b1;
    if (accepted) sb.push_back(d);
    @(posedge clk);
    #1;
    wr_en = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int i;
    i = 0;
    while (!(sb.size() == 0 && empty === 1'b1 && tx_busy === 1'b0) && i < budget) begin
      @(negedge clk);
      i++;
    end
    n_tests++;
    if (i >= budget) begin
      n_fail++;
      $display("FAIL %s_timeout: %0d bytes still pending, empty=%0b after %0d cycles", name, sb.size(), empty, budget);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d bytes pending", sb.size());
    $fatal(1, "watchdog");
  end

  initial begin
    reset   = 1'b1;
    wr_en   = 1'b0;
    wr_data = 8'h00;
`ifdef UART_TX_FIFO_OVF_EN
    ovf_clr = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // 1: reset state and idle
    pulse_cyc.delete();
    repeat (10) @(negedge clk);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'h00);
    check("rst_no_tx_wr", 32'(pulse_cyc.size()), 32'd0);
`ifdef UART_TX_FIFO_OVF_EN
    check("rst_ovf", 32'(ovf), 32'd0);
`endif

    // 2: single byte through an idle core
    @(posedge clk); #1;
    pulse_cyc.delete();
    push(8'h41, 1'b1);
    wait_drain("single", 200);
    check("single_pulses", 32'(pulse_cyc.size()), 32'd1);
    check("single_empty", 32'(empty), 32'd1);

    // 3: fill while core held busy
    hold_busy = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 16; i++) push(8'(i), 1'b1);
    @(negedge clk);
    check("fill_count", 32'(count), 32'd16);
    check("fill_full", 32'(full), 32'd1);
    check("fill_empty", 32'(empty), 32'd0);

    // 4: write while full is dropped
    @(posedge clk); #1;
    push(8'hAA, 1'b0);
    @(negedge clk);
    check("ovf_drop_count", 32'(count), 32'd16);
    check("ovf_drop_full", 32'(full), 32'd1);
`ifdef UART_TX_FIFO_OVF_EN
    check("ovf_set", 32'(ovf), 32'd1);
    repeat (2) @(negedge clk);
    check("ovf_sticky", 32'(ovf), 32'd1);
    @(posedge clk); #1;
    wr_data = 8'hAA;
    wr_en   = 1'b1;
    ovf_clr = 1'b1;
    @(posedge clk); #1;
    wr_en   = 1'b0;
    ovf_clr = 1'b0;
    @(negedge clk);
    check("ovf_set_wins", 32'(ovf), 32'd1);
    @(posedge clk); #1;
    ovf_clr = 1'b1;
    @(posedge clk); #1;
    ovf_clr = 1'b0;
    @(negedge clk);
    check("ovf_clr", 32'(ovf), 32'd0);
    check("ovf_clr_count", 32'(count), 32'd16);
`endif

    // 3 (cont): release core, drain in order
    @(posedge clk); #1;
    pulse_cyc.delete();
    hold_busy = 1'b0;
    wait_drain("burst", 1500);
    check("burst_pulses", 32'(pulse_cyc.size()), 32'd16);
    check("burst_count", 32'(count), 32'd0);
    check("burst_full", 32'(full), 32'd0);

    // 5: core never raises busy -> timeout after BUSY_WAIT cycles
    core_responds = 1'b0;
    @(posedge clk); #1;
    pulse_cyc.delete();
    push(8'h55, 1'b1);
    push(8'h66, 1'b1);
    wait_drain("timeout", 100);
    check("timeout_pulses", 32'(pulse_cyc.size()), 32'd2);
    if (pulse_cyc.size() == 2)
      check("timeout_spacing", 32'(pulse_cyc[1] - pulse_cyc[0]), 32'd6);
    check("timeout_empty", 32'(empty), 32'd1);
    core_responds = 1'b1;

    // 6: reset while in WAIT_DONE with five bytes queued
    @(posedge clk); #1;
    for (int i = 0; i < 6; i++) push(8'hC0 + 8'(i), 1'b1);
    repeat (5) @(negedge clk);
    check("pre_rst_count", 32'(count), 32'd5);
    check("pre_rst_busy", 32'(tx_busy), 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    sb.delete();
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_count", 32'(count), 32'd0);
    check("mid_rst_empty", 32'(empty), 32'd1);
    check("mid_rst_tx_wr", 32'(tx_wr), 32'd0);
    reset = 1'b0;
    pulse_cyc.delete();
    repeat (40) @(negedge clk);
    check("post_rst_no_tx_wr", 32'(pulse_cyc.size()), 32'd0);
    check("post_rst_busy_done", 32'(tx_busy), 32'd0);
    check("post_rst_empty", 32'(empty), 32'd1);

    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
